// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Brief    : Shares one register-file read port among four requesters.
//            Round-robin arbitration; each access reads one register, or a
//            pair of registers, on back-to-back cycles, and returns the
//            words through a registered result port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  pair,
    input  logic [19:0] addr_a,
    input  logic [19:0] addr_b,
    output logic [3:0]  gnt,
    output logic [4:0]  rf_sel,
    input  logic [31:0] rf_data,
    output logic [31:0] rd_data,
    output logic [3:0]  rd_valid,
    output logic        rd_last,
    output logic        busy
);

    localparam int         c_NUM_REQ = 4;
    localparam int         c_AW      = 5;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_A    = 2'd1;
    localparam logic [1:0] c_RD_B    = 2'd2;

    // Latched access context
    logic [1:0] r_state;
    logic [1:0] r_win;
    logic [1:0] r_last_win;
    logic [4:0] r_addr_a;
    logic [4:0] r_addr_b;
    logic       r_pair;

    // Unpacked per-requester register indices
    logic [4:0] w_addr_a [c_NUM_REQ];
    logic [4:0] w_addr_b [c_NUM_REQ];

    logic [3:0] w_win_oh;
    logic [3:0] w_mask;
    logic [3:0] w_elig;
    logic       w_in_a;
    logic       w_in_b;
    logic       w_final;
    logic       w_arb;
    logic       w_found;
    logic [1:0] w_pick;
    logic [1:0] w_idx;

    for (genvar g = 0; g < c_NUM_REQ; g++) begin : g_unpack
        assign w_addr_a[g] = addr_a[g*c_AW +: c_AW];
        assign w_addr_b[g] = addr_b[g*c_AW +: c_AW];
    end

    assign w_in_a   = (r_state == c_RD_A);
    assign w_in_b   = (r_state == c_RD_B);
    assign w_win_oh = 4'b0001 << r_win;

    // The read port frees up after a single read, or after the second word
    // of a pair; a new winner can then start with no idle cycle in between.
    assign w_final  = (w_in_a && !r_pair) || w_in_b;
    assign w_arb    = (r_state == c_IDLE) || w_final;

    // The current winner sits out the edge that ends its first read cycle,
    // so a requester holding req cannot immediately re-win the port.
    assign w_mask   = w_in_a ? w_win_oh : 4'd0;
    assign w_elig   = req & ~w_mask;

    // Round-robin pick: scan upward starting one past the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            w_idx = r_last_win + 2'(i + 1);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Outputs decoded purely from registered state; all zero while idle.
    assign gnt    = w_in_a ? w_win_oh : 4'd0;
    assign rf_sel = w_in_a ? r_addr_a : (w_in_b ? r_addr_b : 5'd0);
    assign busy   = (r_state != c_IDLE);

    // Sequencer: arbitrate whenever the port frees up and latch the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_win      <= 2'd0;
            r_last_win <= 2'd3;
            r_addr_a   <= 5'd0;
            r_addr_b   <= 5'd0;
            r_pair     <= 1'b0;
        end else if (w_arb) begin
            if (w_found) begin
                r_state    <= c_RD_A;
                r_win      <= w_pick;
                r_last_win <= w_pick;
                r_addr_a   <= w_addr_a[w_pick];
                r_addr_b   <= w_addr_b[w_pick];
                r_pair     <= pair[w_pick];
            end else begin
                r_state    <= c_IDLE;
            end
        end else if (w_in_a) begin
            r_state <= c_RD_B;
        end else begin
            r_state <= c_IDLE;
        end
    end

    // Result capture: register the mux output at the end of every read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= 32'd0;
            rd_valid <= 4'd0;
            rd_last  <= 1'b0;
        end else if (w_in_a || w_in_b) begin
            rd_data  <= rf_data;
            rd_valid <= w_win_oh;
            rd_last  <= w_in_b | ~r_pair;
        end else begin
            rd_valid <= 4'd0;
            rd_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Brief    : Self-checking bench for regfile_read_arbiter. A transaction-level
//            reference model predicts grants and returned words; a monitor
//            compares DUT outputs against the predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  req    = 4'd0;
    logic [3:0]  pair   = 4'd0;
    logic [19:0] addr_a = 20'd0;
    logic [19:0] addr_b = 20'd0;
    logic [3:0]  gnt;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic [31:0] rd_data;
    logic [3:0]  rd_valid;
    logic        rd_last;
    logic        busy;

    logic [31:0] regs [32];
    assign rf_data = regs[rf_sel];

    always #5 clk = ~clk;

    regfile_read_arbiter u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .pair     (pair),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .gnt      (gnt),
        .rf_sel   (rf_sel),
        .rf_data  (rf_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- requester agents ----------------
    bit         act    [4];
    bit         sticky [4];
    bit         p_pair [4];
    logic [4:0] p_a    [4];
    logic [4:0] p_b    [4];
    bit         rand_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct {
        int          who;
        logic [31:0] data;
        bit          last;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cur_words[$];
    int         cyc       = 0;
    int         last_w    = 3;
    int         cur_who   = 0;
    bit         cur_first = 1'b0;
    bit         granted [4];
    logic [3:0] exp_gnt   = 4'd0;
    logic [4:0] exp_sel   = 5'd0;
    bit         exp_busy  = 1'b0;

    task automatic model_clear();
        exp_q.delete();
        cur_words.delete();
        last_w    = 3;
        cur_first = 1'b0;
        exp_gnt   = 4'd0;
        exp_sel   = 5'd0;
        exp_busy  = 1'b0;
        for (int i = 0; i < 4; i++) granted[i] = 1'b0;
    endtask

    // One clock edge: retire the word being read, then if the port is free
    // hand it to the next requester in rotation (skipping the one whose
    // first word just completed).
    task automatic model_step();
        int   done_first;
        int   a;
        int   n;
        bit   found;
        exp_t e;
        done_first = -1;
        found      = 1'b0;
        cyc++;
        for (int i = 0; i < 4; i++) granted[i] = 1'b0;
        if (cur_words.size() > 0) begin
            a      = cur_words.pop_front();
            e.who  = cur_who;
            e.data = regs[a];
            e.last = (cur_words.size() == 0);
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (cur_first) done_first = cur_who;
            cur_first = 1'b0;
        end
        if (cur_words.size() == 0) begin
            for (int i = 0; i < 4; i++) begin
                n = (last_w + 1 + i) % 4;
                if (!found && req[n] && n != done_first) begin
                    found      = 1'b1;
                    cur_who    = n;
                    last_w     = n;
                    cur_first  = 1'b1;
                    granted[n] = 1'b1;
                    cur_words.push_back(int'(addr_a[n*5 +: 5]));
                    if (pair[n]) cur_words.push_back(int'(addr_b[n*5 +: 5]));
                end
            end
        end
        exp_gnt  = cur_first ? 4'(1 << cur_who) : 4'd0;
        exp_sel  = (cur_words.size() > 0) ? 5'(cur_words[0]) : 5'd0;
        exp_busy = (cur_words.size() > 0);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("gnt",    32'(gnt),    32'(exp_gnt));
            chk("rf_sel", 32'(rf_sel), 32'(exp_sel));
            chk("busy",   32'(busy),   32'(exp_busy));
            if (rd_valid != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_valid", 32'(rd_valid), 32'(1 << e.who));
                    chk("rd_data",  rd_data,       e.data);
                    chk("rd_last",  32'(rd_last),  32'(e.last));
                    chk("rd_cycle", 32'(cyc),      32'(e.cyc));
                end
            end else begin
                chk("rd_last_idle", 32'(rd_last), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("rd_valid_missing", 32'(rd_valid), 32'(1 << exp_q[0].who));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive();
        for (int n = 0; n < 4; n++) begin
            req[n]            = act[n];
            pair[n]           = act[n] ? p_pair[n] : 1'($urandom_range(0, 1));
            addr_a[n*5 +: 5]  = act[n] ? p_a[n]    : 5'($urandom_range(0, 31));
            addr_b[n*5 +: 5]  = act[n] ? p_b[n]    : 5'($urandom_range(0, 31));
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int n = 0; n < 4; n++)
            if (granted[n] && !sticky[n]) act[n] = 1'b0;
        if (rand_en) begin
            for (int n = 0; n < 4; n++) begin
                if (!act[n] && $urandom_range(0, 2) == 0) begin
                    act[n]    = 1'b1;
                    p_pair[n] = 1'($urandom_range(0, 1));
                    p_a[n]    = 5'($urandom_range(0, 31));
                    p_b[n]    = 5'($urandom_range(0, 31));
                end
            end
        end
        drive();
    endtask

    task automatic issue(input int n, input bit pr, input logic [4:0] a, input logic [4:0] b, input bit st);
        act[n]    = 1'b1;
        sticky[n] = st;
        p_pair[n] = pr;
        p_a[n]    = a;
        p_b[n]    = b;
        drive();
    endtask

    task automatic drop_all();
        for (int n = 0; n < 4; n++) begin
            act[n]    = 1'b0;
            sticky[n] = 1'b0;
        end
        drive();
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release at a negedge.
    task automatic async_reset(input int hold);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_gnt",      32'(gnt),      32'd0);
        chk("rst_rf_sel",   32'(rf_sel),   32'd0);
        chk("rst_rd_data",  rd_data,       32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last",  32'(rd_last),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        drop_all();
        repeat (hold) step();
        reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    logic [3:0] fair_seq [5];
    logic [3:0] mask_gnt [4];
    logic       mask_bsy [4];

    initial begin
        fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mask_gnt = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        mask_bsy = '{1'b1, 1'b0, 1'b1, 1'b0};
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom | 32'h1;
        regs[5] = 32'hDEADBEEF;
        drop_all();

        // Power-on reset
        repeat (3) step();
        chk("por_busy",     32'(busy),     32'd0);
        chk("por_rd_valid", 32'(rd_valid), 32'd0);
        chk("por_rd_data",  rd_data,       32'd0);
        reset = 1'b0;

        // Single read: requester 2, register 5
        issue(2, 1'b0, 5'd5, 5'd0, 1'b0);
        step();
        chk("single_gnt",    32'(gnt),    32'b0100);
        chk("single_rf_sel", 32'(rf_sel), 32'd5);
        step();
        chk("single_rd_valid", 32'(rd_valid), 32'b0100);
        chk("single_rd_data",  rd_data,       32'hDEADBEEF);
        chk("single_rd_last",  32'(rd_last),  32'd1);
        chk("single_gnt_off",  32'(gnt),      32'd0);

        // Paired read: requester 1, registers 8 then 9
        issue(1, 1'b1, 5'd8, 5'd9, 1'b0);
        step();
        chk("pair_gnt",    32'(gnt),    32'b0010);
        chk("pair_sel_a",  32'(rf_sel), 32'd8);
        step();
        chk("pair_gnt_off", 32'(gnt),      32'd0);
        chk("pair_sel_b",   32'(rf_sel),   32'd9);
        chk("pair_v0",      32'(rd_valid), 32'b0010);
        chk("pair_d0",      rd_data,       regs[8]);
        chk("pair_last0",   32'(rd_last),  32'd0);
        step();
        chk("pair_v1",      32'(rd_valid), 32'b0010);
        chk("pair_d1",      rd_data,       regs[9]);
        chk("pair_last1",   32'(rd_last),  32'd1);
        chk("pair_idle",    32'(busy),     32'd0);

        // Asynchronous reset while an access is in flight
        issue(0, 1'b1, 5'd3, 5'd4, 1'b0);
        async_reset(2);

        // Fairness: all four holding req, single reads
        for (int n = 0; n < 4; n++) issue(n, 1'b0, 5'($urandom_range(0, 31)), 5'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_gnt", 32'(gnt), 32'(fair_seq[k]));
        end
        drop_all();
        repeat (3) step();

        // Masking: a lone requester holding req gets every other cycle
        issue(0, 1'b0, 5'd7, 5'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mask_gnt",  32'(gnt),  32'(mask_gnt[k]));
            chk("mask_busy", 32'(busy), 32'(mask_bsy[k]));
        end
        drop_all();
        repeat (3) step();

        // Reset during the second word of a pair
        issue(3, 1'b1, 5'd10, 5'd11, 1'b0);
        step();
        async_reset(1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
            chk("mrst_busy",     32'(busy),     32'd0);
        end
        issue(1, 1'b0, 5'd12, 5'd0, 1'b0);
        issue(3, 1'b0, 5'd13, 5'd0, 1'b0);
        step();
        chk("mrst_first_gnt", 32'(gnt), 32'b0010);
        step();
        chk("mrst_second_gnt", 32'(gnt), 32'b1000);
        drop_all();
        repeat (3) step();

        // Randomized traffic with one reset in the middle
        rand_en = 1'b1;
        repeat (1500) step();
        async_reset(1);
        repeat (1500) step();
        rand_en = 1'b0;
        drop_all();
        repeat (10) step();
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy",  32'(busy),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 Parameter: none; requester count fixed at 4, register address width 5, data width 32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  4  per-requester read request; bit n = requester n.
REQ-006 pair  in  4  per-requester: 1 = read two registers (addr_a then addr_b), 0 = addr_a only.
REQ-007 addr_a  in  20  packed 4x5; bits [5n+4:5n] = requester n first register index.
REQ-008 addr_b  in  20  packed 4x5; bits [5n+4:5n] = requester n second register index.
REQ-009 gnt  out  4  one-hot grant pulse.
REQ-010 rf_sel  out  5  select driven to the 32-to-1 register read mux.
REQ-011 rf_data  in  32  read mux output; combinational function of rf_sel; register 0 reads 0.
REQ-012 rd_data  out  32  registered read result.
REQ-013 rd_valid  out  4  one-hot: rd_data valid for requester n this cycle.
REQ-014 rd_last  out  1  qualifies rd_valid: final word of the access.
REQ-015 busy  out  1  high when state != IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RD_A, RD_B; all outputs registered or decoded from registered state only.
REQ-017 Arbitration SHALL be round-robin over eligible req bits, priority starting at (last_winner+1) mod 4.
REQ-018 At an edge in IDLE with any eligible req: latch winner w, addr_a[w], addr_b[w], pair[w]; update last_winner=w; go RD_A.
REQ-019 In RD_A: gnt = onehot(w) for exactly that cycle, rf_sel = latched addr_a.
REQ-020 In RD_B: gnt = 0, rf_sel = latched addr_b.
REQ-021 In IDLE: gnt = 0, rf_sel = 0.
REQ-022 Edge ending RD_A: rd_data<=rf_data, rd_valid<=onehot(w), rd_last<=~pair_latched; go RD_B if pair_latched.
REQ-023 Edge ending RD_B: rd_data<=rf_data, rd_valid<=onehot(w), rd_last<=1.
REQ-024 At any other edge rd_valid<=0, rd_last<=0; rd_data holds.
REQ-025 Edge ending final read cycle (RD_A with pair=0, or RD_B): arbitrate again; new winner -> RD_A directly, none -> IDLE; no bubble between accesses.
REQ-026 At the edge ending w's RD_A cycle, req[w] SHALL be masked (ineligible); it is eligible again from the next edge.
REQ-027 Latency: req sampled at edge E -> gnt during cycle after E -> first rd_valid one cycle later; pair second word the following cycle.
REQ-028 Requester SHALL hold req, pair, addr_a, addr_b stable until gnt; inputs are don't-care after gnt.
REQ-029 Throughput: one register read per cycle while any requester is eligible.
REQ-030 addr 0 SHALL be passed through unchanged; result is whatever rf_data returns (0).

Reset
REQ-031 On reset assertion, regardless of clock: state=IDLE, last_winner=3, gnt=0, rf_sel=0, rd_data=0, rd_valid=0, rd_last=0, busy=0.
REQ-032 Reset mid-access SHALL abandon the access; no rd_valid for it after deassertion; requester must re-request.
REQ-033 First grant after reset SHALL go to the lowest-indexed requester asserting req.

Verification
REQ-034 Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, busy=0.
REQ-035 Single: req=0100, pair=0, addr_a[2]=5, reg5=0xDEADBEEF -> next cycle gnt=0100, rf_sel=5; following cycle rd_valid=0100, rd_data=0xDEADBEEF, rd_last=1.
REQ-036 Pair: req=0010, pair[1]=1, addr_a=8, addr_b=9 -> rf_sel 8 then 9 consecutive cycles, gnt=0010 one cycle only; rd_valid=0010 two cycles, rd_last 0 then 1.
REQ-037 Fairness: req=1111 held, pair=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, no idle cycle.
REQ-038 Masking: req=0001 held continuously, pair=0 -> grant every other cycle (grant, idle, grant), busy toggling accordingly.
REQ-039 Reset mid-pair: assert reset during RD_B -> rd_valid stays 0 after release, busy=0, next grant to lowest-indexed active req.
